// File: rtl/bram_ring_feeder.sv
// Put/get message bridge to a dual-port BRAM that holds a TX ring, an RX ring and four pointer words.
// Owns one BRAM port: writes messages and pointers, and polls the pointers the CPU writes.
module bram_ring_feeder #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 14,
    parameter int RING_LOG2 = 8,
    parameter int TX_BASE   = 16,
    parameter int RX_BASE   = 272,
    parameter int POLL_GAP  = 15
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [DATA_W-1:0]   msg_put,
    input  logic                EN_msg_put,
    output logic                RDY_msg_put,
    input  logic                EN_msg_get,
    output logic [DATA_W-1:0]   msg_get,
    output logic                RDY_msg_get,
    output logic                bram_clk,
    output logic                bram_rst,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_wen,
    output logic [31:0]         bram_addr,
    output logic [DATA_W-1:0]   bram_dout,
    input  logic [DATA_W-1:0]   bram_din
);
    localparam int BSH = $clog2(DATA_W / 8);
    localparam int PCW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
    localparam logic [ADDR_W-1:0] TX_HEAD_W = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] TX_TAIL_W = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RX_HEAD_W = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] RX_TAIL_W = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);
    localparam logic [ADDR_W-1:0] RX_BASE_A = ADDR_W'(RX_BASE);

    typedef enum logic [3:0] {
        INIT0 = 4'd0, INIT1 = 4'd1, INIT2 = 4'd2, INIT3 = 4'd3,
        IDLE, TX_DATA, TX_PTR, RD_TXTAIL, WAIT_TXTAIL,
        RD_RXHEAD, WAIT_RXHEAD, RX_DATA, WAIT_RXDATA, RX_PTR
    } stateT;

    stateT                 state;
    logic [RING_LOG2-1:0]  txHead, txTailCache, rxTail;
    logic [RING_LOG2-1:0]  txHeadInc, rxTailInc, rxHeadSeen;
    logic [PCW-1:0]        pollCnt;
    logic                  inValid, outValid, initDone, txFull;
    logic [DATA_W-1:0]     inData, outData;
    logic [ADDR_W-1:0]     wordAddr;

    // Pointers live zero-extended in full BRAM words.
    function automatic logic [DATA_W-1:0] ptrWord(input logic [RING_LOG2-1:0] p);
        return DATA_W'(p);
    endfunction

    // Slot index never exceeds the ring depth, so base+index stays inside its own ring.
    function automatic logic [ADDR_W-1:0] slotAddr(input logic [ADDR_W-1:0] base,
                                                   input logic [RING_LOG2-1:0] idx);
        return base + ADDR_W'(idx);
    endfunction

    assign txHeadInc   = txHead + RING_LOG2'(1);
    assign rxTailInc   = rxTail + RING_LOG2'(1);
    assign rxHeadSeen  = bram_din[RING_LOG2-1:0];
    assign txFull      = (txHeadInc == txTailCache);

    assign bram_clk    = CLK;
    assign bram_rst    = ~RST_N;
    assign bram_addr   = 32'(wordAddr) << BSH;
    assign RDY_msg_put = initDone & ~inValid;
    assign RDY_msg_get = outValid;
    assign msg_get     = outData;

    // Port outputs are registered on entry to the state that owns the BRAM access.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= INIT0;
            txHead      <= '0;
            txTailCache <= '0;
            rxTail      <= '0;
            pollCnt     <= '0;
            inValid     <= 1'b0;
            outValid    <= 1'b0;
            initDone    <= 1'b0;
            inData      <= '0;
            outData     <= '0;
            wordAddr    <= '0;
            bram_en     <= 1'b0;
            bram_wen    <= '0;
            bram_dout   <= '0;
        end else begin
            if (EN_msg_put) begin
                inData  <= msg_put;
                inValid <= 1'b1;
            end
            if (EN_msg_get)
                outValid <= 1'b0;
            bram_en  <= 1'b0;
            bram_wen <= '0;
            case (state)
                INIT0, INIT1, INIT2, INIT3: begin
                    bram_en   <= 1'b1;
                    bram_wen  <= '1;
                    bram_dout <= '0;
                    wordAddr  <= ADDR_W'(state);
                    state     <= (state == INIT3) ? IDLE : stateT'(state + 4'd1);
                end
                IDLE: begin
                    initDone <= 1'b1;
                    if (pollCnt != '0)
                        pollCnt <= pollCnt - 1'b1;
                    if (inValid && !txFull) begin
                        bram_en   <= 1'b1;
                        bram_wen  <= '1;
                        bram_dout <= inData;
                        wordAddr  <= slotAddr(TX_BASE_A, txHead);
                        state     <= TX_DATA;
                    end else if (inValid) begin
                        bram_en  <= 1'b1;
                        wordAddr <= TX_TAIL_W;
                        state    <= RD_TXTAIL;
                    end else if (!outValid && pollCnt == '0) begin
                        bram_en  <= 1'b1;
                        wordAddr <= RX_HEAD_W;
                        state    <= RD_RXHEAD;
                    end
                end
                // Data slot is written one cycle before the head pointer that publishes it.
                TX_DATA: begin
                    bram_en   <= 1'b1;
                    bram_wen  <= '1;
                    bram_dout <= ptrWord(txHeadInc);
                    wordAddr  <= TX_HEAD_W;
                    state     <= TX_PTR;
                end
                TX_PTR: begin
                    txHead  <= txHeadInc;
                    inValid <= 1'b0;
                    state   <= IDLE;
                end
                RD_TXTAIL:   state <= WAIT_TXTAIL;
                WAIT_TXTAIL: begin
                    txTailCache <= bram_din[RING_LOG2-1:0];
                    state       <= IDLE;
                end
                RD_RXHEAD:   state <= WAIT_RXHEAD;
                WAIT_RXHEAD: begin
                    if (rxHeadSeen != rxTail) begin
                        bram_en  <= 1'b1;
                        wordAddr <= slotAddr(RX_BASE_A, rxTail);
                        state    <= RX_DATA;
                    end else begin
                        pollCnt <= PCW'(POLL_GAP);
                        state   <= IDLE;
                    end
                end
                RX_DATA:     state <= WAIT_RXDATA;
                WAIT_RXDATA: begin
                    outData   <= bram_din;
                    outValid  <= 1'b1;
                    bram_en   <= 1'b1;
                    bram_wen  <= '1;
                    bram_dout <= ptrWord(rxTailInc);
                    wordAddr  <= RX_TAIL_W;
                    state     <= RX_PTR;
                end
                // Poll counter left at zero so queued RX messages drain back-to-back.
                RX_PTR: begin
                    rxTail <= rxTailInc;
                    state  <= IDLE;
                end
                default: state <= INIT0;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_ring_feeder.sv
// Directed bench for bram_ring_feeder: a default-size instance plus a 4-deep ring instance for RX wrap.
// Each instance is attached to a simple 1-cycle-latency BRAM model with a CPU-side write port.
module tb_bram_ring_feeder;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // default instance
    logic [31:0] msgPut = '0, msgGet, bDout, bDin = '0, bAddr;
    logic        enPut = 1'b0, rdyPut, enGet = 1'b0, rdyGet, bClk, bRst, bEn;
    logic [3:0]  bWen;
    logic [31:0] mem [0:1023];
    logic        cpuWe = 1'b0;
    logic [9:0]  cpuAddr = '0;
    logic [31:0] cpuData = '0;
    logic [31:0] wrA[$], wrD[$], rdA[$];

    // 4-deep ring instance
    logic [31:0] msgGet2, bDout2, bDin2 = '0, bAddr2;
    logic        rdyPut2, enGet2 = 1'b0, rdyGet2, bClk2, bRst2, bEn2;
    logic [3:0]  bWen2;
    logic [31:0] mem2 [0:15];
    logic        cpu2We = 1'b0;
    logic [3:0]  cpu2Addr = '0;
    logic [31:0] cpu2Data = '0;
    logic [31:0] rd2A[$], tail2D[$];

    always #5 CLK = ~CLK;

    bram_ring_feeder dut (
        .CLK(CLK), .RST_N(RST_N), .msg_put(msgPut), .EN_msg_put(enPut), .RDY_msg_put(rdyPut),
        .EN_msg_get(enGet), .msg_get(msgGet), .RDY_msg_get(rdyGet), .bram_clk(bClk),
        .bram_rst(bRst), .bram_en(bEn), .bram_wen(bWen), .bram_addr(bAddr),
        .bram_dout(bDout), .bram_din(bDin)
    );

    bram_ring_feeder #(.RING_LOG2(2), .TX_BASE(4), .RX_BASE(8), .POLL_GAP(3)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .msg_put(32'h0), .EN_msg_put(1'b0), .RDY_msg_put(rdyPut2),
        .EN_msg_get(enGet2), .msg_get(msgGet2), .RDY_msg_get(rdyGet2), .bram_clk(bClk2),
        .bram_rst(bRst2), .bram_en(bEn2), .bram_wen(bWen2), .bram_addr(bAddr2),
        .bram_dout(bDout2), .bram_din(bDin2)
    );

    always @(posedge CLK) begin
        if (bEn) begin
            for (int b = 0; b < 4; b++)
                if (bWen[b]) mem[bAddr[11:2]][8*b +: 8] <= bDout[8*b +: 8];
            bDin <= mem[bAddr[11:2]];
            if (bWen != 4'h0) begin
                wrA.push_back(bAddr);
                wrD.push_back(bDout);
            end else begin
                rdA.push_back(bAddr);
            end
        end
        if (cpuWe) mem[cpuAddr] <= cpuData;
    end

    always @(posedge CLK) begin
        if (bEn2) begin
            for (int b = 0; b < 4; b++)
                if (bWen2[b]) mem2[bAddr2[5:2]][8*b +: 8] <= bDout2[8*b +: 8];
            bDin2 <= mem2[bAddr2[5:2]];
            if (bWen2 == 4'h0 && bAddr2 >= 32'h20) rd2A.push_back(bAddr2);
            if (bWen2 != 4'h0 && bAddr2 == 32'hC) tail2D.push_back(bDout2);
        end
        if (cpu2We) mem2[cpu2Addr] <= cpu2Data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearLog();
        wrA.delete();
        wrD.delete();
        rdA.delete();
    endtask

    function automatic int countRd(input logic [31:0] a);
        int n = 0;
        foreach (rdA[i]) if (rdA[i] == a) n++;
        return n;
    endfunction

    task automatic cpuWrite(input logic [9:0] a, input logic [31:0] d);
        cpuAddr = a;
        cpuData = d;
        cpuWe   = 1'b1;
        step();
        cpuWe   = 1'b0;
    endtask

    task automatic cpu2Write(input logic [3:0] a, input logic [31:0] d);
        cpu2Addr = a;
        cpu2Data = d;
        cpu2We   = 1'b1;
        step();
        cpu2We   = 1'b0;
    endtask

    task automatic putMsg(input logic [31:0] d);
        for (int n = 0; n < 40 && !rdyPut; n++) step();
        check("put_rdy", rdyPut, 1);
        msgPut = d;
        enPut  = 1'b1;
        step();
        enPut  = 1'b0;
    endtask

    task automatic waitRdyPut();
        for (int n = 0; n < 40 && !rdyPut; n++) step();
    endtask

    initial begin
        int ringWrites;
        int rdyGetSeen;
        int found;
        int expSlot[6] = '{0, 1, 2, 3, 0, 1};
        int expTail[6] = '{1, 2, 3, 0, 1, 2};

        // reset state
        step();
        step();
        check("rst_en", bEn, 0);
        check("rst_wen", bWen, 0);
        check("rst_addr", bAddr, 0);
        check("rst_dout", bDout, 0);
        check("rst_rdyput", rdyPut, 0);
        check("rst_rdyget", rdyGet, 0);
        check("rst_msgget", msgGet, 0);
        check("rst_bramrst", bRst, 1);
        check("rst_bramrst2", bRst2, 1);
        check("bram_clk", {bClk, bClk2}, {CLK, CLK});
        RST_N = 1'b1;
        #1;
        check("bram_rst_rel", bRst, 0);

        // INIT writes on cycles 1..4, ready on cycle 5
        for (int k = 0; k < 4; k++) begin
            step();
            check("init_en", {bEn, bWen}, {1'b1, 4'hF});
            check("init_addr", bAddr, 4 * k);
            check("init_dout", bDout, 0);
            check("init_rdyput", rdyPut, 0);
        end
        step();
        check("idle_rdyput", rdyPut, 1);
        check("idle_rdyget", rdyGet, 0);

        // single TX message
        clearLog();
        putMsg(32'hDEADBEEF);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            if (bEn && bWen == 4'hF && bAddr == 32'h0) found = 1;
            else step();
        end
        check("tx_ptr_seen", found, 1);
        check("tx_rdy_during_ptr", rdyPut, 0);
        step();
        check("tx_rdy_after_ptr", rdyPut, 1);
        check("tx_nwr", wrA.size(), 2);
        check("tx_data_addr", wrA[0], 32'h40);
        check("tx_data", wrD[0], 32'hDEADBEEF);
        check("tx_ptr_addr", wrA[1], 32'h0);
        check("tx_ptr", wrD[1], 1);

        // single RX message
        clearLog();
        cpuWrite(10'd272, 32'hCAFEF00D);
        cpuWrite(10'd2, 32'd1);
        for (int n = 0; n < 25 && !rdyGet; n++) step();
        check("rx_rdy", rdyGet, 1);
        check("rx_data", msgGet, 32'hCAFEF00D);
        step();
        step();
        check("rx_nwr", wrA.size(), 1);
        check("rx_tail_addr", wrA[0], 32'hC);
        check("rx_tail", wrD[0], 1);
        enGet = 1'b1;
        step();
        enGet = 1'b0;
        check("rx_get_clears", rdyGet, 0);
        clearLog();
        repeat (40) step();
        check("rx_no_reread", countRd(32'h440), 0);
        check("rx_polls_resume", countRd(32'h8) > 0, 1);
        check("rx_no_redeliver", rdyGet, 0);

        // fill the TX ring: 254 more puts make 255 accepted
        for (int i = 1; i <= 254; i++) putMsg(32'h1000_0000 + i);
        waitRdyPut();
        step();
        check("fill_head", mem[0], 255);
        check("fill_slot1", mem[17], 32'h1000_0001);
        check("fill_slot254", mem[270], 32'h1000_00FE);
        putMsg(32'h5A5A5A5A);
        clearLog();
        repeat (30) step();
        check("full_rdyput", rdyPut, 0);
        check("full_no_writes", wrA.size(), 0);
        check("full_tail_polls", countRd(32'h4) >= 8, 1);
        check("full_only_tail", countRd(32'h4), rdA.size());
        cpuWrite(10'd1, 32'd10);
        clearLog();
        waitRdyPut();
        check("unfull_rdyput", rdyPut, 1);
        check("wrap_data_addr", wrA[0], 32'h43C);
        check("wrap_data", wrD[0], 32'h5A5A5A5A);
        check("wrap_ptr_addr", wrA[1], 32'h0);
        check("wrap_ptr", wrD[1], 0);
        clearLog();
        putMsg(32'h77);
        waitRdyPut();
        check("after_wrap_addr", wrA[0], 32'h40);
        check("after_wrap_data", wrD[0], 32'h77);
        check("after_wrap_ptr", wrD[1], 1);

        // hold an RX message, then reset in the middle of a TX pointer write
        cpuWrite(10'd273, 32'hBEEF0002);
        cpuWrite(10'd2, 32'd2);
        for (int n = 0; n < 25 && !rdyGet; n++) step();
        check("rx2_data", {rdyGet, msgGet}, {1'b1, 32'hBEEF0002});
        putMsg(32'hABCD0001);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            if (bEn && bWen == 4'hF && bAddr == 32'h0) found = 1;
            else step();
        end
        check("mid_ptr_seen", found, 1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_en", {bEn, bWen}, 0);
        check("mid_rst_addr", bAddr, 0);
        check("mid_rst_dout", bDout, 0);
        check("mid_rst_rdy", {rdyPut, rdyGet}, 0);
        check("mid_rst_msg", msgGet, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("reinit_addr", {bEn, bWen, bAddr}, {1'b1, 4'hF, 32'(4 * k)});
        end
        clearLog();
        rdyGetSeen = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (rdyGet) rdyGetSeen++;
        end
        ringWrites = 0;
        foreach (wrA[i]) if (wrA[i] >= 32'h10) ringWrites++;
        check("reinit_no_stale_get", rdyGetSeen, 0);
        check("reinit_no_stale_put", ringWrites, 0);
        check("reinit_rdyput", rdyPut, 1);

        // RX wrap on the 4-deep ring: 6 messages in two batches of 3
        check("r2_rdyput", rdyPut2, 1);
        rd2A.delete();
        tail2D.delete();
        for (int k = 0; k < 3; k++) cpu2Write(4'(8 + k), 32'hA0 + k);
        cpu2Write(4'd2, 32'd3);
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30 && !rdyGet2; n++) step();
            check("r2_msg", {rdyGet2, msgGet2}, {1'b1, 32'hA0 + 32'(k)});
            enGet2 = 1'b1;
            step();
            enGet2 = 1'b0;
        end
        cpu2Write(4'd11, 32'hA3);
        cpu2Write(4'd8, 32'hA4);
        cpu2Write(4'd9, 32'hA5);
        cpu2Write(4'd2, 32'd2);
        for (int k = 3; k < 6; k++) begin
            for (int n = 0; n < 30 && !rdyGet2; n++) step();
            check("r2_msg", {rdyGet2, msgGet2}, {1'b1, 32'hA0 + 32'(k)});
            enGet2 = 1'b1;
            step();
            enGet2 = 1'b0;
        end
        repeat (10) step();
        check("r2_nreads", rd2A.size(), 6);
        check("r2_ntails", tail2D.size(), 6);
        for (int j = 0; j < 6; j++) begin
            check("r2_slot", rd2A[j], 32'h20 + 32'(4 * expSlot[j]));
            check("r2_tail", tail2D[j], 32'(expTail[j]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bram_ring_feeder.md
Name: bram_ring_feeder

Overview:
- Parametrised successor to the single-word BRAM message feeder.
- Bridges the FPGA-side put/get message interface to a dual-port BRAM shared with the soft processor.
- The shared BRAM holds two ring buffers (TX: FPGA->CPU, RX: CPU->FPGA) plus four pointer words.
- The block owns one BRAM port. It writes messages and pointers, and polls the CPU-written pointers.

Parameters:
- DATA_W, 32: message and BRAM word width. Must be a multiple of 8, power of two, 32..128.
- ADDR_W, 14: BRAM word-address width.
- RING_LOG2, 8: log2 of ring depth, in words.
- TX_BASE, 16: word address of TX ring slot 0.
- RX_BASE, 272: word address of RX ring slot 0. TX_BASE and RX_BASE are each >= 4; RX_BASE + 2^RING_LOG2 <= 2^ADDR_W; the rings do not overlap.
- POLL_GAP, 15: idle cycles between successive RX-head polls.

Ports:
- CLK, in, 1: clock.
- RST_N, in, 1: asynchronous active-low reset.
- msg_put, in, DATA_W: input message.
- EN_msg_put, in, 1: put strobe. Asserted only while RDY_msg_put is high.
- RDY_msg_put, out, 1: input slot free.
- EN_msg_get, in, 1: get strobe. Asserted only while RDY_msg_get is high.
- msg_get, out, DATA_W: output message.
- RDY_msg_get, out, 1: output message valid.
- bram_clk, out, 1: equals CLK.
- bram_rst, out, 1: ~RST_N, combinational.
- bram_en, out, 1: port enable.
- bram_wen, out, DATA_W/8: byte write enables.
- bram_addr, out, 32: byte address = zero-extended {word_addr, log2(DATA_W/8) zero bits}.
- bram_dout, out, DATA_W: write data.
- bram_din, in, DATA_W: read data, valid exactly 1 cycle after a bram_en read cycle.

Behaviour:
- BRAM control words (word addresses):
  - 0 TX_HEAD: written by block.
  - 1 TX_TAIL: written by CPU.
  - 2 RX_HEAD: written by CPU.
  - 3 RX_TAIL: written by block.
- Pointers:
  - Stored zero-extended; only bits [RING_LOG2-1:0] are used on read.
  - All pointer arithmetic is modulo 2^RING_LOG2.
  - Ring full when tx_head+1 == tx_tail_cache (one slot always kept empty).
  - Ring empty when head == tail.
- Reset values:
  - bram_en=0, bram_wen=0, bram_addr=0, bram_dout=0.
  - RDY_msg_put=0, RDY_msg_get=0, msg_get=0.
  - Local tx_head, tx_tail_cache, rx_tail = 0; poll counter = 0; state = INIT0.
  - Reset asserted mid-operation aborts any transaction immediately; state re-enters INIT0.
- INIT0..INIT3:
  - Write 0 to words 0..3 (all wen bits set), one per cycle, then IDLE.
  - RDY_msg_put stays 0 until IDLE is reached: 4 cycles after reset release.
- Input slot:
  - RDY_msg_put = init_done & ~in_valid.
  - EN_msg_put latches msg_put and sets in_valid.
- Output slot:
  - RDY_msg_get = out_valid; msg_get = out_data.
  - EN_msg_get clears out_valid.
  - Put and get in the same cycle are both accepted.
- IDLE priority, evaluated each cycle; the poll counter decrements to 0 while in IDLE:
  1. in_valid & ~full -> TX_DATA.
  2. in_valid & full -> RD_TXTAIL.
  3. ~out_valid & poll counter == 0 -> RD_RXHEAD.
  4. Otherwise stay in IDLE, bram_en=0.
- TX path:
  - TX_DATA: write in_data to TX_BASE+tx_head.
  - TX_PTR: write tx_head+1 to word 0; tx_head++; clear in_valid; -> IDLE.
  - The data write always precedes the pointer write, so the CPU never sees an unwritten slot.
- TX tail refresh:
  - RD_TXTAIL: read word 1.
  - WAIT_TXTAIL: tx_tail_cache <= bram_din[RING_LOG2-1:0]; -> IDLE.
  - While the ring stays full, the block re-polls continuously. Each round is 3 cycles: RD_TXTAIL, WAIT_TXTAIL, IDLE.
- RX path:
  - RD_RXHEAD: read word 2.
  - WAIT_RXHEAD: if din low bits != rx_tail -> RX_DATA; else reload poll counter with POLL_GAP and -> IDLE.
  - RX_DATA: read RX_BASE+rx_tail.
  - WAIT_RXDATA: out_data <= bram_din; out_valid <= 1.
  - RX_PTR: write rx_tail+1 to word 3; rx_tail++; -> IDLE. The poll counter is not reloaded, so back-to-back messages drain without gaps.
- Latency:
  - Put to TX pointer write: 2 cycles minimum from IDLE.
  - CPU RX_HEAD update to RDY_msg_get: at most POLL_GAP+5 cycles when the output slot is free.
- Wrap-around: slot index rolls from 2^RING_LOG2-1 to 0. The base address plus index never carries into the other ring.
- The output slot holds one message; RX polling is suspended while out_valid=1 (backpressure).

Test Plan:
- Reset release -> writes 0 to addresses 0x0,0x4,0x8,0xC on cycles 1-4; RDY_msg_put rises on cycle 5; RDY_msg_get stays 0.
- Put 0xDEADBEEF -> write to byte addr 0x40 (TX_BASE=16) then write 1 to 0x0; RDY_msg_put returns high on the cycle after the pointer write.
- CPU model writes 0xCAFEF00D at word 272 and RX_HEAD=1 -> RDY_msg_get with 0xCAFEF00D within 20 cycles; write 1 to 0xC; no further reads of slot data until the next head change.
- Send 255 puts while the CPU never advances TX_TAIL -> 255 accepted, 256th held with RDY_msg_put=0 and repeated reads of 0x4; CPU sets TX_TAIL=10 -> the held message is written to slot 255, then tx_head wraps to 0.
- RX wrap with RING_LOG2=2: CPU produces 6 messages -> all 6 delivered in order; data reads alternate slots 0,1,2,3,0,1; RX_TAIL sequence is 1,2,3,0,1,2.
- Assert RST_N low during TX_PTR -> all outputs go to reset values asynchronously; after release the INIT sequence repeats and no stale message is emitted.
